// File: rtl/sobel_sweep_pkg.sv
// Shared definitions for the Sobel sweep engine and the edge coprocessor:
// PCPI instruction encoding, image-layout helpers and the sweep FSM states.
package sobel_sweep_pkg;

    localparam logic [6:0]  PCPI_OPCODE_SOBEL = 7'b0101011;
    localparam logic [6:0]  PCPI_FUNCT7_SOBEL = 7'b0000001;
    localparam logic [31:0] PCPI_INSN_SOBEL   = {PCPI_FUNCT7_SOBEL, 18'b0, PCPI_OPCODE_SOBEL};

    // Row and column indices are 9 bits wide (images up to 512x512).
    localparam int RC_W = 9;

    localparam int          DEF_ROWS     = 512;
    localparam int          DEF_COLS     = 512;
    localparam logic [31:0] DEF_OUT_BASE = 32'd540672;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WRITE = 3'd2,
        ST_NEXT  = 3'd3,
        ST_DONE  = 3'd4
    } sweep_state_t;

    // Number of words occupied by one image.
    function automatic logic [31:0] img_size(input int rows, input int cols);
        return 32'(rows * cols);
    endfunction

    // Word offset of image 'img' inside an image region.
    function automatic logic [31:0] img_offset(input logic [31:0] img, input int rows,
                                               input int cols);
        return img * img_size(rows, cols);
    endfunction

    // Word index of one pixel in the output region; wraps modulo 2^32.
    function automatic logic [31:0] pixel_word(input logic [31:0] base, input logic [31:0] img,
                                               input logic [RC_W-1:0] row,
                                               input logic [RC_W-1:0] col,
                                               input int rows, input int cols);
        return base + img_offset(img, rows, cols)
             + ({23'b0, row} * 32'(cols)) + {23'b0, col};
    endfunction

    // Saturate the coprocessor result to an 8-bit pixel.
    function automatic logic [7:0] clamp_pixel(input logic [31:0] v);
        return (v > 32'd255) ? 8'hFF : v[7:0];
    endfunction

endpackage

// File: rtl/sobel_sweep_raster_ctr.sv
// Row-major raster counter: col runs fastest, wraps into the next row.
// o_last flags the final pixel of the image.
module raster_ctr
    import sobel_sweep_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            i_clear,
    input  logic            i_step,
    output logic [RC_W-1:0] o_row,
    output logic [RC_W-1:0] o_col,
    output logic            o_last
);

    localparam logic [RC_W-1:0] ROW_MAX = RC_W'(ROWS - 1);
    localparam logic [RC_W-1:0] COL_MAX = RC_W'(COLS - 1);

    logic [RC_W-1:0] r_row;
    logic [RC_W-1:0] r_col;
    logic            w_col_end;

    assign w_col_end = (r_col == COL_MAX);

    // Advance one pixel per step; clear restarts at the top-left corner.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_clear) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_step) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_last = w_col_end && (r_row == ROW_MAX);

endmodule

// File: rtl/sobel_sweep.sv
// Sobel sweep engine: walks every pixel of an image in raster order, asks
// the edge coprocessor (PCPI) for the filtered value, saturates it to 8 bits
// and writes it into the output image region.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | PCPI request outstanding, wait timer running
// WRITE | result write outstanding on the memory port
// NEXT  | advance raster position or finish
// DONE  | one-cycle completion pulse
module sobel_sweep
    import sobel_sweep_pkg::*;
#(
    parameter int          ROWS     = DEF_ROWS,
    parameter int          COLS     = DEF_COLS,
    parameter logic [31:0] OUT_BASE = DEF_OUT_BASE,
    parameter int          TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [31:0] img_sel,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        pcpi_valid,
    output logic [31:0] pcpi_insn,
    output logic [31:0] pcpi_rs1,
    output logic [31:0] pcpi_rs2,
    input  logic        pcpi_wr,
    input  logic [31:0] pcpi_rd,
    input  logic        pcpi_wait,
    input  logic        pcpi_ready,
    output logic        mem_valid,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready
);

    localparam int                WAIT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(TIMEOUT - 1);

    sweep_state_t    r_state;
    logic [31:0]     r_img;
    logic [31:0]     r_result;
    logic [WAIT_W-1:0] r_wait;
    logic            r_err;
    logic            r_busy;
    logic            r_done;
    logic            r_pcpi_valid;
    logic            r_mem_valid;

    logic [RC_W-1:0] w_row;
    logic [RC_W-1:0] w_col;
    logic            w_last;
    logic            w_clear;
    logic            w_step;
    logic [31:0]     w_word;
    logic [7:0]      w_pixel;
    logic            w_unused;

    // The coprocessor's write-back and wait hints carry no meaning here.
    assign w_unused = ^{pcpi_wr, pcpi_wait};

    assign w_clear = (r_state == ST_IDLE) && start;
    assign w_step  = (r_state == ST_NEXT) && !w_last;

    raster_ctr #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_raster_ctr (
        .clk     (clk),
        .resetn  (resetn),
        .i_clear (w_clear),
        .i_step  (w_step),
        .o_row   (w_row),
        .o_col   (w_col),
        .o_last  (w_last)
    );

    assign w_word  = pixel_word(OUT_BASE, r_img, w_row, w_col, ROWS, COLS);
    assign w_pixel = clamp_pixel(r_result);

    // Sweep sequencer; all handshake outputs are registered with the state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_img        <= '0;
            r_result     <= '0;
            r_wait       <= '0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pcpi_valid <= 1'b0;
            r_mem_valid  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_img        <= img_sel;
                        r_err        <= 1'b0;
                        r_wait       <= WAIT_LOAD;
                        r_busy       <= 1'b1;
                        r_pcpi_valid <= 1'b1;
                        r_state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (pcpi_ready) begin
                        r_result     <= pcpi_rd;
                        r_pcpi_valid <= 1'b0;
                        r_mem_valid  <= 1'b1;
                        r_state      <= ST_WRITE;
                    end else if (r_wait == '0) begin
                        // Silent coprocessor: write a black pixel and flag it.
                        r_result     <= '0;
                        r_err        <= 1'b1;
                        r_pcpi_valid <= 1'b0;
                        r_mem_valid  <= 1'b1;
                        r_state      <= ST_WRITE;
                    end else begin
                        r_wait <= r_wait - 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (mem_ready) begin
                        r_mem_valid <= 1'b0;
                        r_state     <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (w_last) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_wait       <= WAIT_LOAD;
                        r_pcpi_valid <= 1'b1;
                        r_state      <= ST_ISSUE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;

    // Request fields are only driven while the request is valid, so they
    // are held stable for its whole duration and read zero otherwise.
    assign pcpi_valid = r_pcpi_valid;
    assign pcpi_insn  = r_pcpi_valid ? PCPI_INSN_SOBEL : '0;
    assign pcpi_rs1   = r_pcpi_valid ? r_img : '0;
    assign pcpi_rs2   = r_pcpi_valid ? {14'b0, w_row, w_col} : '0;

    assign mem_valid  = r_mem_valid;
    assign mem_write  = r_mem_valid;
    assign mem_addr   = r_mem_valid ? {w_word[29:0], 2'b00} : '0;
    assign mem_wdata  = r_mem_valid ? {24'b0, w_pixel} : '0;

endmodule
